// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared constants and types for the eight-way round-robin mux scheduler.
package mux8_rr_scheduler_pkg;

  localparam int unsigned NUM_REQ      = 8;
  localparam int unsigned SEL_W        = 3;
  localparam int unsigned MAX_HOLD_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // One-hot vector with only bit i set.
  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// Request/data bundle between the requesters and the scheduler.
interface mux8_rr_scheduler_if;
  import mux8_rr_scheduler_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] in;
  logic [SEL_W-1:0]   sel;
  logic [NUM_REQ-1:0] grant;
  logic               out;
  logic               out_valid;

  // Requester side: drives requests and data, observes the grant and mux output.
  modport master (
    output req, in,
    input  sel, grant, out, out_valid
  );

  // Scheduler side.
  modport slave (
    input  req, in,
    output sel, grant, out, out_valid
  );
endinterface

// File: rtl/mux8_rr_scheduler_pick.sv
// Combinational round-robin pick: first set request at or after ptr, mod 8.
module rr_pick8
  import mux8_rr_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;
  logic               hit;

  // Rotate right by ptr, priority-encode the lowest bit, then add ptr back.
  always_comb begin
    rot = '0;
    off = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rot[i] && !hit) begin
        off = SEL_W'(i);
        hit = 1'b1;
      end
    end
    idx   = off + ptr;
    found = hit;
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 single-bit mux, with a bounded hold time.
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned HOLD_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux8_rr_scheduler_if.slave   bus
);

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   sel_r;
  logic [NUM_REQ-1:0] grant_r;
  logic               out_r;
  logic               valid_r;

  logic               busy;
  logic               expire;
  logic               cur_req;
  logic [SEL_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;

  // One picker serves both cases: in BUSY it already looks from sel+1 with the
  // current holder masked, which is exactly what a release needs.
  always_comb begin
    busy     = (state == ST_BUSY);
    expire   = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    cur_req  = bus.req[sel_r];
    pick_ptr = busy ? sel_r + SEL_W'(1) : ptr;
    pick_req = busy ? (bus.req & ~onehot8(sel_r)) : bus.req;
  end

  rr_pick8 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Arbitration FSM, hold counter, pointer and registered mux output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      ptr      <= '0;
      sel_r    <= '0;
      grant_r  <= '0;
      out_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (|grant_r) out_r <= bus.in[sel_r];
      valid_r <= |grant_r;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_r  <= onehot8(pick_idx);
            sel_r    <= pick_idx;
            hold_cnt <= '0;
            state    <= ST_BUSY;
          end else begin
            grant_r <= '0;
          end
        end
        ST_BUSY: begin
          if (!cur_req || expire) begin
            ptr <= sel_r + SEL_W'(1);
            if (pick_found) begin
              grant_r  <= onehot8(pick_idx);
              sel_r    <= pick_idx;
              hold_cnt <= '0;
            end else if (cur_req) begin
              // Hold expired but nobody else wants the mux: re-grant in place.
              hold_cnt <= '0;
            end else begin
              grant_r <= '0;
              state   <= ST_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_r;
  assign bus.grant     = grant_r;
  assign bus.out       = out_r;
  assign bus.out_valid = valid_r;

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
Round-robin scheduler that shares one 8:1 single-bit multiplexer between eight requesters. It registers the one-hot grant and the 3-bit select that steer the mux, and bounds each grant to MAX_HOLD cycles so that no requester can starve the others. The selected bit is registered and presented with a valid qualifier to the downstream consumer.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant (legal range 1..16).
HOLD_W, 4, width of the hold counter; must satisfy 2**HOLD_W >= MAX_HOLD.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  8  per-requester request; req[i] is held high while requester i wants the mux.
in  input  8  mux data inputs; in[i] belongs to requester i.
sel  output  3  registered mux select; equals the index of the current grant.
grant  output  8  registered one-hot grant; all zero when idle.
out  output  1  registered in[sel], captured one cycle after the cycle in which sel is applied.
out_valid  output  1  qualifies out; high exactly one cycle after each cycle with grant != 0.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: sel=0, grant=0, out=0, out_valid=0, state=IDLE, hold_cnt=0, ptr=0. ptr is the highest-priority index for the next arbitration.
- Pick function: first i with req[i]=1, searching ptr, ptr+1, ..., ptr+7, all mod 8. It is combinational and evaluated every cycle.
- State IDLE:
  - If req == 0: stay in IDLE; grant=0.
  - Otherwise: on the next edge grant=onehot(pick), sel=pick, hold_cnt=0, go to BUSY.
  - Latency from req rising to grant is 1 cycle.
- State BUSY, release condition: req[sel]==0, or hold_cnt==MAX_HOLD-1.
  - A request drop and hold expiry in the same cycle count as a single release.
- BUSY, no release: hold_cnt increments; sel and grant are held.
- BUSY, on release:
  - ptr <= sel+1 (mod 8, so 7 wraps to 0).
  - Re-arbitrate in the same cycle using the updated pointer, with req[sel] masked when the release is a hold expiry.
  - If a winner exists, the next edge loads the new grant/sel with hold_cnt=0. Back-to-back grants have no idle bubble.
  - If no winner exists and the release is a hold expiry with req[sel] still high, the current requester is re-granted and hold_cnt restarts at 0.
  - Otherwise (no winner): grant=0 and go to IDLE.
- Data path: every cycle, out <= in[sel] and out_valid <= |grant.
  - While idle, out holds its last value and out_valid=0.
- MAX_HOLD=1: the grant rotates every cycle whenever two or more requesters are active.
- A requester that drops req mid-grant loses the grant after that cycle. Its final out sample is still marked valid.
- rst asserted mid-BUSY: the next edge forces all reset values. No partial grant survives.
- grant is always one-hot or zero. sel is meaningful only when grant != 0.

Decomposition:
- Shared package: state encoding localparams (ST_IDLE=1'b0, ST_BUSY=1'b1), the default MAX_HOLD, and the NUM_REQ=8 and SEL_W=3 constants.
- One sub-module, rr_pick8: purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], found.
  - Implementation: rotate right by ptr, priority-encode, then add ptr back mod 8.
- The top level holds the FSM, hold counter, pointer, and output registers.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with req=8'hFF. Required: grant=0, sel=0, out_valid=0 throughout. After release, the first edge gives grant=8'h01, sel=0.
2. Single requester: req=8'b0000_1000, in=8'b0000_1001, MAX_HOLD=4. Required: sel=3 one cycle later; out=1 with out_valid=1 the following cycle. The grant is re-issued to 3 after 4 cycles with no idle gap.
3. Round-robin fairness: req=8'b0100_0100 held constant. Required: grant alternates 3'd2 (4 cycles), 3'd6 (4 cycles), 3'd2, and so on. out tracks in[2]/in[6] with 1-cycle lag.
4. Early release and wrap: grant at 7, then req[7] drops while req=8'b0000_0011. Required: next grant is sel=0 (ptr wrapped to 0), then sel=1 after its hold.
5. Simultaneous events: at hold expiry for requester 5, req[5] also drops and req[2] rises in the same cycle. Required: a single release and grant=8'h04 on the next edge.
6. Reset mid-operation: assert rst while sel=6 and hold_cnt=2. Required: next edge gives grant=0, out_valid=0, ptr=0. With req=8'h40 after release, the grant is to 6 with hold_cnt restarted at 0.
